// File: rtl/fft_frame_streamer_if.sv
// Sample input and AXI-stream output bundle for the FFT frame streamer.
// Latency: none; this file only carries wires.
// Backpressure: fft_tready_in flows from the FFT core back to the streamer.
interface fft_frame_streamer_if #(
    parameter int SAMPLE_W = 8
);
    logic [SAMPLE_W-1:0] sample_in;
    logic                sample_valid_in;
    logic                audio_done_in;
    logic [31:0]         fft_tdata_out;
    logic                fft_tvalid_out;
    logic                fft_tlast_out;
    logic                fft_tready_in;

    // streamer side: consumes samples, drives the AXI data channel
    modport master (
        input  sample_in,
        input  sample_valid_in,
        input  audio_done_in,
        input  fft_tready_in,
        output fft_tdata_out,
        output fft_tvalid_out,
        output fft_tlast_out
    );

    // environment side: recorder playback plus FFT core input
    modport slave (
        output sample_in,
        output sample_valid_in,
        output audio_done_in,
        output fft_tready_in,
        input  fft_tdata_out,
        input  fft_tvalid_out,
        input  fft_tlast_out
    );
endinterface

// File: rtl/fft_frame_streamer.sv
// Buffers recorder samples and streams them to the FFT core as fixed-length frames, zero-padding the last one.
// Latency: a sample written into an empty FIFO is presented on tdata/tvalid the next cycle (first-word fall-through).
// Backpressure: tready stalls the FIFO head; samples arriving while the FIFO is full (and not popping) are dropped and flagged.
module fft_frame_streamer #(
    parameter int FRAME_LEN  = 2048,
    parameter int SAMPLE_W   = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    fft_frame_streamer_if.master bus,
    output logic [15:0]          frame_count_out,
    output logic                 busy_out,
    output logic                 done_out,
    output logic                 overflow_out
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(FRAME_LEN);

    typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_PAD, ST_DONE} state_t;

    state_t              state_q, state_d;
    logic [AW:0]         wr_ptr_q, wr_ptr_d;
    logic [AW:0]         rd_ptr_q, rd_ptr_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;
    logic                done_flag_q, done_flag_d;
    logic                overflow_q, overflow_d;
    logic [SAMPLE_W-1:0] mem_q [FIFO_DEPTH];

    logic                fifo_empty, fifo_full, data_vld, tvalid, xfer, pop, push, last_idx;
    logic [SAMPLE_W-1:0] head;
    logic [15:0]         real_dat;

    // FIFO status, handshake decode and registered-only output derivation
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        head       = mem_q[rd_ptr_q[AW-1:0]];
        data_vld   = (state_q == ST_STREAM) && !fifo_empty;
        tvalid     = data_vld || (state_q == ST_PAD);
        xfer       = tvalid && bus.fft_tready_in;
        pop        = xfer && (state_q == ST_STREAM);
        last_idx   = (idx_q == IW'(FRAME_LEN - 1));
        // only IDLE and STREAM accept samples; a full FIFO accepts only when it pops the same cycle
        push       = bus.sample_valid_in && ((state_q == ST_IDLE) || (state_q == ST_STREAM))
                     && (!fifo_full || pop);
        real_dat   = data_vld ? (16'(head) << (16 - SAMPLE_W)) : 16'h0000;
    end

    assign bus.fft_tdata_out  = {16'h0000, real_dat};
    assign bus.fft_tvalid_out = tvalid;
    assign bus.fft_tlast_out  = tvalid && last_idx;
    assign frame_count_out    = frame_cnt_q;
    assign busy_out           = (state_q == ST_STREAM) || (state_q == ST_PAD);
    assign done_out           = (state_q == ST_DONE);
    assign overflow_out       = overflow_q;

    // next-state, frame index, frame counter and sticky flag logic
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q + (AW + 1)'(push);
        rd_ptr_d    = rd_ptr_q + (AW + 1)'(pop);
        idx_d       = idx_q;
        frame_cnt_d = frame_cnt_q;
        done_flag_d = done_flag_q || bus.audio_done_in;
        overflow_d  = overflow_q || (bus.sample_valid_in && !push);

        if (xfer) begin
            idx_d = idx_q + 1'b1;
            if (last_idx && (frame_cnt_q != 16'hFFFF)) begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.sample_valid_in) begin
                    state_d     = ST_STREAM;
                    overflow_d  = 1'b0;
                    frame_cnt_d = 16'h0000;
                end else if (bus.audio_done_in) begin
                    state_d = ST_DONE;
                end
            end
            ST_STREAM: begin
                // drained after playback ended: finish the partial frame with zeros, or stop on a boundary
                if (done_flag_q && fifo_empty && !push) begin
                    state_d = (idx_q != '0) ? ST_PAD : ST_DONE;
                end
            end
            ST_PAD: begin
                if (xfer && last_idx) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_flag_d = 1'b0;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // control state registers; reset abandons any frame in flight
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            idx_q       <= '0;
            frame_cnt_q <= 16'h0000;
            done_flag_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            idx_q       <= idx_d;
            frame_cnt_q <= frame_cnt_d;
            done_flag_q <= done_flag_d;
            overflow_q  <= overflow_d;
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= bus.sample_in;
        end
    end
endmodule

// File: tb/tb_fft_frame_streamer.sv
module tb_fft_frame_streamer;
    localparam int L = 2048;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    always #5 clk_in = ~clk_in;

    fft_frame_streamer_if #(.SAMPLE_W(8)) bus ();
    logic [15:0] frame_count;
    logic        busy, done, overflow;

    fft_frame_streamer #(.FRAME_LEN(L), .SAMPLE_W(8), .FIFO_DEPTH(16)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .bus             (bus),
        .frame_count_out (frame_count),
        .busy_out        (busy),
        .done_out        (done),
        .overflow_out    (overflow)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // monitor: sole writer of the beat log, done counter and stability error counter
    logic [31:0] beat_dat[$];
    logic        beat_last[$];
    int          done_cnt  = 0;
    int          stab_err  = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_dat   = '0;
    logic        prev_last  = 1'b0;

    always @(negedge clk_in) begin
        if (!rst_in) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!bus.fft_tvalid_out || bus.fft_tdata_out !== prev_dat ||
                               bus.fft_tlast_out !== prev_last)) begin
                stab_err++;
            end
            if (bus.fft_tvalid_out && bus.fft_tready_in) begin
                beat_dat.push_back(bus.fft_tdata_out);
                beat_last.push_back(bus.fft_tlast_out);
            end
            if (done) done_cnt++;
            prev_stall = bus.fft_tvalid_out && !bus.fft_tready_in;
            prev_dat   = bus.fft_tdata_out;
            prev_last  = bus.fft_tlast_out;
        end
    end

    bit         rnd_rdy = 1'b0;
    logic [7:0] ev[$];

    task automatic tick();
        @(posedge clk_in);
        #1;
        if (rnd_rdy) bus.fft_tready_in = 1'($urandom_range(0, 1));
    endtask

    task automatic push_sample(input logic [7:0] v, input int gap);
        bus.sample_in       = v;
        bus.sample_valid_in = 1'b1;
        tick();
        bus.sample_valid_in = 1'b0;
        repeat (gap - 1) tick();
    endtask

    task automatic pulse_done();
        bus.audio_done_in = 1'b1;
        tick();
        bus.audio_done_in = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 6000) begin
            tick();
            n++;
        end
        check_val({tag, "_done_seen"}, 32'(done_cnt != d0), 1);
        repeat (3) tick();
        check_val({tag, "_done_pulses"}, done_cnt - d0, 1);
    endtask

    task automatic verify_beats(input string tag, input int base, input int nd, input int nexp);
        int          mism = 0;
        logic [31:0] exp_d;
        logic        exp_l;
        check_val({tag, "_beat_count"}, beat_dat.size() - base, nexp);
        for (int j = 0; j < nexp && (base + j) < beat_dat.size(); j++) begin
            exp_d = (j < nd) ? {16'h0000, ev[j], 8'h00} : 32'h0;
            exp_l = ((j % L) == L - 1);
            if (beat_dat[base + j] !== exp_d || beat_last[base + j] !== exp_l) mism++;
        end
        check_val({tag, "_beat_mismatches"}, mism, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_tvalid"}, 32'(bus.fft_tvalid_out), 0);
        check_val({tag, "_tlast"},  32'(bus.fft_tlast_out), 0);
        check_val({tag, "_tdata"},  bus.fft_tdata_out, 0);
        check_val({tag, "_fcount"}, 32'(frame_count), 0);
        check_val({tag, "_busy"},   32'(busy), 0);
        check_val({tag, "_done"},   32'(done), 0);
        check_val({tag, "_ovf"},    32'(overflow), 0);
    endtask

    initial begin
        int base, d0, s0;
        bus.sample_in       = '0;
        bus.sample_valid_in = 1'b0;
        bus.audio_done_in   = 1'b0;
        bus.fft_tready_in   = 1'b1;

        // reset state
        repeat (3) @(posedge clk_in);
        #2;
        check_all_zero("rst");
        rst_in = 1'b1;
        tick();
        check_all_zero("post_rst");

        // T1: one exact frame, slow arrivals, always ready
        base = beat_dat.size(); d0 = done_cnt; ev.delete();
        for (int i = 0; i < 2048; i++) begin
            ev.push_back(8'(i));
            push_sample(8'(i), 7);
        end
        pulse_done();
        wait_done("t1", d0);
        verify_beats("t1", base, 2048, 2048);
        check_val("t1_fcount", 32'(frame_count), 1);
        check_val("t1_ovf", 32'(overflow), 0);
        check_val("t1_busy", 32'(busy), 0);

        // T2: 3000 samples, partial second frame padded with zeros
        base = beat_dat.size(); d0 = done_cnt; ev.delete();
        for (int i = 0; i < 3000; i++) begin
            ev.push_back(8'(i));
            push_sample(8'(i), 2);
        end
        pulse_done();
        wait_done("t2", d0);
        verify_beats("t2", base, 3000, 4096);
        check_val("t2_fcount", 32'(frame_count), 2);

        // T3: random tready, stream must match the always-ready run and hold stable while stalled
        base = beat_dat.size(); d0 = done_cnt; s0 = stab_err; ev.delete();
        rnd_rdy = 1'b1;
        for (int i = 0; i < 2048; i++) begin
            ev.push_back(8'(i));
            push_sample(8'(i), 3);
        end
        pulse_done();
        wait_done("t3", d0);
        rnd_rdy = 1'b0;
        bus.fft_tready_in = 1'b1;
        tick();
        verify_beats("t3", base, 2048, 2048);
        check_val("t3_stable", stab_err - s0, 0);
        check_val("t3_fcount", 32'(frame_count), 1);

        // T4: stalled sink, 20 back-to-back samples -> 16 kept, rest dropped
        base = beat_dat.size(); d0 = done_cnt; s0 = stab_err; ev.delete();
        bus.fft_tready_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i < 16) ev.push_back(8'(8'h10 + i));
            push_sample(8'(8'h10 + i), 1);
        end
        check_val("t4_ovf_set", 32'(overflow), 1);
        repeat (5) tick();
        check_val("t4_ovf_sticky", 32'(overflow), 1);
        check_val("t4_head_valid", 32'(bus.fft_tvalid_out), 1);
        check_val("t4_head_dat", bus.fft_tdata_out, 32'h0000_1000);
        bus.fft_tready_in = 1'b1;
        pulse_done();
        wait_done("t4", d0);
        verify_beats("t4", base, 16, 2048);
        check_val("t4_ovf_end", 32'(overflow), 1);
        check_val("t4_stable", stab_err - s0, 0);
        check_val("t4_fcount", 32'(frame_count), 1);

        // T5: full FIFO with push and pop in the same cycle -> no drop
        base = beat_dat.size(); d0 = done_cnt; ev.delete();
        bus.fft_tready_in = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ev.push_back(8'(8'h40 + i));
            push_sample(8'(8'h40 + i), 1);
        end
        check_val("t5_ovf_cleared", 32'(overflow), 0);
        ev.push_back(8'h50);
        bus.sample_in       = 8'h50;
        bus.sample_valid_in = 1'b1;
        bus.fft_tready_in   = 1'b1;
        tick();
        bus.sample_valid_in = 1'b0;
        check_val("t5_ovf_pushpop", 32'(overflow), 0);
        pulse_done();
        wait_done("t5", d0);
        verify_beats("t5", base, 17, 2048);
        check_val("t5_ovf_end", 32'(overflow), 0);

        // T6: asynchronous reset mid-frame, then restart from index 0
        bus.fft_tready_in = 1'b1;
        for (int i = 0; i < 1001; i++) push_sample(8'(i), 1);
        check_val("t6_busy_before", 32'(busy), 1);
        #2;
        rst_in = 1'b0;
        #1;
        check_all_zero("t6_async");
        tick();
        tick();
        #2;
        rst_in = 1'b1;
        tick();
        check_val("t6_fcount_after", 32'(frame_count), 0);
        base = beat_dat.size(); d0 = done_cnt; ev.delete();
        ev.push_back(8'h77);
        bus.sample_in       = 8'h77;
        bus.sample_valid_in = 1'b1;
        tick();
        bus.sample_valid_in = 1'b0;
        check_val("t6_lat_valid", 32'(bus.fft_tvalid_out), 1);
        check_val("t6_lat_dat", bus.fft_tdata_out, 32'h0000_7700);
        check_val("t6_lat_last", 32'(bus.fft_tlast_out), 0);
        for (int i = 1; i < 2048; i++) begin
            ev.push_back(8'(i));
            push_sample(8'(i), 1);
        end
        pulse_done();
        wait_done("t6", d0);
        verify_beats("t6", base, 2048, 2048);
        check_val("t6_fcount", 32'(frame_count), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fft_frame_streamer.md
Name: fft_frame_streamer

Overview:
- AXI-stream master that feeds the FFT core's input data channel. It sits between the recorder playback output and the FFT core.
- 8-bit signed samples arrive from the recorder with a valid strobe and are buffered in a small FIFO.
- The block emits them as FRAME_LEN-sample frames with tvalid/tlast, honouring tready backpressure.
- When playback ends mid-frame, it zero-pads the partial frame to FRAME_LEN so the FFT never sees a short frame.

Parameters:
FRAME_LEN, 2048, samples per FFT frame; power of two, 16..65536.
SAMPLE_W, 8, input sample width (signed).
FIFO_DEPTH, 16, input buffer entries; power of two.

Ports:
clk_in  input  1  system clock (100 MHz).
rst_in  input  1  asynchronous, active-low reset.
sample_in  input  SAMPLE_W  signed audio sample from recorder playback.
sample_valid_in  input  1  single-cycle strobe; sample_in is valid this cycle.
audio_done_in  input  1  single-cycle pulse; playback finished, no more samples follow.
fft_tdata_out  output  32  [15:0] real = {sample, (16-SAMPLE_W) zeros}; [31:16] imag = 0.
fft_tvalid_out  output  1  AXI tvalid.
fft_tlast_out  output  1  AXI tlast; high on frame index FRAME_LEN-1 only.
fft_tready_in  input  1  AXI tready from the FFT core.
frame_count_out  output  16  number of frames completed since start; saturates at 0xFFFF.
busy_out  output  1  high in STREAM or PAD.
done_out  output  1  single-cycle pulse when the stream ends.
overflow_out  output  1  sticky; a sample was dropped because the FIFO was full.

Behaviour:
- Reset (rst_in low, asynchronous):
  - FIFO is emptied and the state is IDLE.
  - Frame index = 0, frame_count_out = 0.
  - All outputs are 0.
  - Reset mid-frame abandons the frame; no tlast is issued.
- States:
  - IDLE: FIFO is empty and tvalid = 0. The first sample_valid_in writes the FIFO and moves to STREAM; this also clears overflow_out and frame_count_out.
  - STREAM:
    - tvalid = FIFO not empty; tdata is built from the FIFO head.
    - A transfer occurs on tvalid & tready. It pops the head and increments the frame index.
    - The index wraps from FRAME_LEN-1 to 0, and that transfer increments frame_count_out.
    - A latched done flag (set by audio_done_in) with an empty FIFO moves to PAD if index != 0, else to DONE.
  - PAD: tvalid = 1 with tdata = 0. It transfers zeros until the index-FRAME_LEN-1 beat (with tlast) is accepted, then goes to DONE.
  - DONE: pulses done_out for one cycle, clears the done flag, and returns to IDLE.
- AXI rules:
  - Once tvalid is high, tdata and tlast stay stable until accepted.
  - tvalid never drops without a transfer, except on reset.
  - tlast = tvalid & (index == FRAME_LEN-1).
  - All outputs are derived from registers only; there is no combinational path from tready to tvalid or tdata.
- Latency: a sample written at edge k is visible on tdata/tvalid in cycle k+1 if the FIFO was empty. The FIFO is first-word-fall-through.
- FIFO boundary cases:
  - A write when full drops the sample and sets overflow_out, except when a pop occurs the same cycle, in which case both succeed.
  - A write and pop on an empty FIFO in the same cycle is not possible, because tvalid is 0 when empty.
  - Write and read pointers are log2(FIFO_DEPTH)+1 bits, with full/empty decided by the MSB compare.
- Simultaneous events:
  - audio_done_in in the same cycle as sample_valid_in: the sample is still accepted and the done flag is set.
  - audio_done_in while in IDLE with no samples: go straight to DONE (done_out pulse, frame_count_out stays 0).
  - sample_valid_in during PAD or DONE is dropped and sets overflow_out.
- frame_count_out increments only on an accepted tlast beat.

Test Plan:
- Reset, then 2048 samples (value i mod 256, one every 7 cycles), tready=1, then audio_done_in → 2048 beats with tdata[15:8] = i mod 256; tlast only on beat 2047; frame_count_out=1; done_out pulses once; no PAD beats.
- 3000 samples then done → 2048 + 952 data beats, then 1096 zero beats; tlast on beats 2047 and 4095; frame_count_out=2.
- tready toggled pseudo-randomly (50%) during stream → tdata/tlast stable while tvalid & !tready; beat sequence identical to the tready=1 run.
- tready=0 for 20 cycles, sample every cycle → 16 samples accepted, the 17th dropped; overflow_out=1 and stays 1; after tready=1 the 16 values emerge in order.
- FIFO full with push and pop in the same cycle → no drop; overflow_out stays 0.
- rst_in low at beat 1000 → all outputs 0 immediately (async); a new sample after reset restarts at index 0 with frame_count_out=0.
